aer_event_encoder: RTL
======================

# aer_event_encoder

Synchronous transmit stage feeding the AER output receiver/decoder chain. Captures single-cycle spike events on four channel lines (Ch1Up, Ch1Down, Ch2Up, Ch2Down), arbitrates them round-robin, and serialises each one as a frame of 4-phase return-to-zero dual-rail symbols on Bit0/Bit1. It completes every symbol with the downstream ack handshake. It is the block that drives the Bit0/Bit1/ack pins of the AER output decoder.

## Interface
- SYNC_STAGES, 2, flops in the ack synchroniser (≥2)
- ACK_TIMEOUT, 1024, cycles allowed per ack phase before a frame is aborted; 0 disables the timeout
- COUNT_W, 8, width of the drop counter
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- Ch1Up, Ch1Down, Ch2Up, Ch2Down  in  1 each  event pulses, synchronous to clk, one event per high cycle
- ack  in  1  receiver acknowledge, asynchronous, synchronised internally
- Bit0  out  1  dual-rail zero rail, registered
- Bit1  out  1  dual-rail one rail, registered
- busy  out  1  high while a frame is in flight (state ≠ IDLE)
- timeout_err  out  1  sticky: an ack phase exceeded ACK_TIMEOUT
- drop_count  out  COUNT_W  saturating count of events lost because the line was already pending

## Operation
- Symbol codes on {Bit1,Bit0}: 01 = data 0; 10 = data 1; 11 = delimiter; 00 = spacer.
- Frame: delimiter, channel bit (0 = Ch1, 1 = Ch2), direction bit (0 = Up, 1 = Down), delimiter. The frame has four symbols, and each symbol is followed by a spacer.
- Each event line has a sticky pending flag, set by a high input.
  - If the input is high while its flag is already set (and the flag is not being granted that cycle), drop_count increments, saturating at all-ones.
- Arbiter order: Ch1Up, Ch1Down, Ch2Up, Ch2Down.
  - Search starts at the line after the last granted line.
  - After reset the search starts at Ch1Up.
  - A grant clears that line's flag in the same cycle.
  - An input pulse on the granted line in the grant cycle re-sets the flag and is not counted as a drop.
- FSM states: IDLE, DRIVE, RTZ, RECOVER. A symbol index sym[1:0] tracks position in the frame.
  - IDLE: if any flag is set, grant a line, latch its channel and direction bits, load the delimiter, set sym=0, go to DRIVE.
  - DRIVE: Bit lines hold the current code. When synced ack = 1, drive 00 and go to RTZ.
  - RTZ: Bit lines hold 00. When synced ack = 0:
    - if sym = 3, go to IDLE;
    - otherwise increment sym, load the next code, go to DRIVE.
  - Timeout: a cycle counter clears on every entry to DRIVE or RTZ. If it reaches ACK_TIMEOUT in either state:
    - drive 00;
    - set timeout_err;
    - go to RECOVER.
  - RECOVER: wait for synced ack = 0, then go to IDLE. There is no timeout in RECOVER. The aborted event is discarded and is not counted in drop_count.
- Bit0 and Bit1 are never both changed from one non-spacer code to another; a spacer always separates codes.
- Pending flags keep capturing events in every state.

## Timing
- Reset values: Bit0=0, Bit1=0, busy=0, timeout_err=0, drop_count=0. All flags are clear, the arbiter pointer is at Ch1Up, the FSM is in IDLE, and the synchroniser is all zero.
- Reset is asynchronous: assertion forces the outputs above immediately, including mid-frame. After deassertion the block starts in IDLE.
- Event-to-bus latency from IDLE: pulse sampled at edge N sets the flag; grant at edge N+1; Bit lines = 11 after edge N+1.
- ack-to-Bit latency: ack edge → SYNC_STAGES edges → Bit lines change on the next edge.
- Back-to-back frames: after the final RTZ completes, the FSM spends one cycle in IDLE before the next DRIVE. The gap is 1 cycle.
- busy goes high on the grant edge and low on the edge that enters IDLE.

## Test plan
- Single event, fast ack. Ch2Down pulse with a receiver model that acks after 3 cycles → Bit sequence 11, 00, 10, 00, 10, 00, 11, 00. busy high for the frame only; drop_count=0.
- Simultaneous events. Ch1Up and Ch2Up pulse in the same cycle → Ch1Up frame (11,01,01,11), then Ch2Up frame (11,10,01,11). No drops.
- Drop counting. Ch1Down pulsed 3 times while a Ch2Up frame is in flight, with no intervening Ch1Down grant → drop_count=2 and exactly one Ch1Down frame sent. With COUNT_W=2, 5 drops saturate drop_count at 3.
- Round-robin. All four lines held pending continuously → grant order Ch1Up, Ch1Down, Ch2Up, Ch2Down, repeating.
- Timeout. ACK_TIMEOUT=16 with ack stuck low → Bit lines return to 00 on cycle 16 of DRIVE and timeout_err=1. Ack then pulsed high and low → RECOVER exits to IDLE and the next pending event transmits.
- Reset mid-frame. Assert reset during DRIVE of the channel-bit symbol → Bit0=Bit1=0 and busy=0 immediately. After release, with no new events, the bus stays 00.

Source files
------------

// File: rtl/aer_event_encoder.sv
// aer_event_encoder: captures spike events on four lines, arbitrates them
// round-robin and sends each one as a four-symbol dual-rail RTZ frame
// (delimiter, channel, direction, delimiter). Every symbol completes a
// 4-phase handshake with the receiver's ack.
// Ports:
//   clk, reset (async, active-low)
//   Ch1Up/Ch1Down/Ch2Up/Ch2Down : one-cycle event pulses (one event per high cycle)
//   ack                         : asynchronous receiver acknowledge
//   Bit0/Bit1                   : registered dual-rail symbol outputs
//   busy                        : a frame is in flight
//   timeout_err                 : sticky ack-phase timeout flag
//   drop_count                  : saturating count of events lost on an already-pending line
module aer_event_encoder #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 1024,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Ch1Up,
  input  logic               Ch1Down,
  input  logic               Ch2Up,
  input  logic               Ch2Down,
  input  logic               ack,
  output logic               Bit0,
  output logic               Bit1,
  output logic               busy,
  output logic               timeout_err,
  output logic [COUNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RTZ, S_RECOVER} state_t;

  localparam int              TO_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = (ACK_TIMEOUT == 0) ? '0 : TO_W'(ACK_TIMEOUT - 1);
  localparam logic            TO_EN   = (ACK_TIMEOUT != 0);

  // Line index: 0 Ch1Up, 1 Ch1Down, 2 Ch2Up, 3 Ch2Down.
  // Bit 1 of the index is the channel bit, bit 0 the direction bit.
  logic [3:0]             w_ev;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_sym, w_sym_nxt;
  logic [1:0]           r_line, w_line_nxt;
  logic [1:0]           r_bits, w_bits_nxt;
  logic [1:0]           r_ptr, w_ptr_nxt;
  logic                 r_err, w_err_nxt;
  logic [TO_W-1:0]      r_cnt, w_cnt_nxt;
  logic                 w_to;
  logic [3:0]           r_pend;
  logic [COUNT_W-1:0]   r_drop;

  logic                 w_any_vld;
  logic                 w_gnt;
  logic [1:0]           w_gnt_idx;
  logic [3:0]           w_gnt_mask;
  logic [3:0]           w_drop;
  logic [2:0]           w_ndrop;
  logic [COUNT_W+2:0]   w_sum;

  assign w_ev  = {Ch2Down, Ch2Up, Ch1Down, Ch1Up};
  assign w_ack = r_ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ack_sync <= '0;
    else        r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack};
  end

  // Round-robin search starting at the line after r_ptr. Scanning from the
  // farthest candidate down lets the nearest pending line win.
  always_comb begin
    w_any_vld = 1'b0;
    w_gnt_idx = r_ptr;
    for (int k = 4; k >= 1; k--) begin
      if (r_pend[r_ptr + 2'(k)]) begin
        w_any_vld = 1'b1;
        w_gnt_idx = r_ptr + 2'(k);
      end
    end
  end

  assign w_gnt      = (r_state == S_IDLE) && w_any_vld;
  assign w_gnt_mask = w_gnt ? (4'b0001 << w_gnt_idx) : 4'b0000;
  // A pulse on the line being granted re-arms it rather than counting as lost.
  assign w_drop     = w_ev & r_pend & ~w_gnt_mask;
  assign w_ndrop    = 3'(w_drop[0]) + 3'(w_drop[1]) + 3'(w_drop[2]) + 3'(w_drop[3]);
  assign w_sum      = (COUNT_W+3)'(r_drop) + (COUNT_W+3)'(w_ndrop);

  assign w_to = TO_EN && (r_cnt == TO_LAST);

  function automatic logic [1:0] f_code(input logic [1:0] sym, input logic [1:0] line);
    case (sym)
      2'd1:    f_code = {line[1], ~line[1]};
      2'd2:    f_code = {line[0], ~line[0]};
      default: f_code = 2'b11;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_sym_nxt   = r_sym;
    w_line_nxt  = r_line;
    w_bits_nxt  = r_bits;
    w_ptr_nxt   = r_ptr;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_gnt) begin
          w_state_nxt = S_DRIVE;
          w_sym_nxt   = 2'd0;
          w_line_nxt  = w_gnt_idx;
          w_ptr_nxt   = w_gnt_idx;
          w_bits_nxt  = 2'b11;
        end
      end
      S_DRIVE: begin
        if (w_ack) begin
          w_bits_nxt  = 2'b00;
          w_state_nxt = S_RTZ;
        end else if (w_to) begin
          w_bits_nxt  = 2'b00;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RECOVER;
        end
      end
      S_RTZ: begin
        if (!w_ack) begin
          if (r_sym == 2'd3) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_sym_nxt   = r_sym + 2'd1;
            w_bits_nxt  = f_code(r_sym + 2'd1, r_line);
            w_state_nxt = S_DRIVE;
          end
        end else if (w_to) begin
          w_bits_nxt  = 2'b00;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RECOVER;
        end
      end
      S_RECOVER: begin
        // Aborted event is simply discarded once the receiver lets go of ack.
        if (!w_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Phase timer restarts on every entry to DRIVE or RTZ.
  always_comb begin
    w_cnt_nxt = '0;
    if ((w_state_nxt == r_state) && ((r_state == S_DRIVE) || (r_state == S_RTZ)))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sym   <= '0;
      r_line  <= '0;
      r_bits  <= '0;
      r_ptr   <= 2'd3;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sym   <= w_sym_nxt;
      r_line  <= w_line_nxt;
      r_bits  <= w_bits_nxt;
      r_ptr   <= w_ptr_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= (r_pend & ~w_gnt_mask) | w_ev;
      if (w_sum[COUNT_W+2:COUNT_W] != 3'd0) r_drop <= '1;
      else                                  r_drop <= w_sum[COUNT_W-1:0];
    end
  end

  assign Bit0        = r_bits[0];
  assign Bit1        = r_bits[1];
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_err;
  assign drop_count  = r_drop;

endmodule
